// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the register-file write-port
//                arbiter and its MDU result FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Arbiter FSM: normal sharing, or a forced MDU drain slot.
    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } state_t;

    // One queued MDU write. live=0 marks an entry squashed by a younger write.
    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One-hot decode of a register number.
    function automatic logic [31:0] reg_onehot(input logic [4:0] i_addr);
        return 32'd1 << i_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Circular buffer of pending MDU writes with an address-match
//                squash port and a pending-register mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  entry_t                   i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_squash,
    input  logic [4:0]               i_squash_addr,
    output entry_t                   o_head,
    output logic                     o_head_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_pend_mask
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(DEPTH);

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W:0]     r_count;
    logic [31:0]          w_mask;

    // Storage, pointers and occupancy; popped slots are marked dead so the
    // mask only needs the live bits, never the pointer range.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].addr == i_squash_addr) begin
                        r_mem[i].live <= 1'b0;
                    end
                end
            end
            if (i_pop) begin
                r_mem[r_rd].live <= 1'b0;
                r_rd             <= r_rd + 1'b1;
            end
            if (i_push) begin
                r_mem[r_wr] <= i_push_entry;
                r_wr        <= r_wr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pending-write mask from registered live bits only.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                w_mask = w_mask | reg_onehot(r_mem[i].addr);
            end
        end
    end

    assign o_head       = r_mem[r_rd];
    assign o_head_valid = (r_count != '0);
    assign o_full       = (r_count == c_FULL);
    assign o_count      = r_count;
    assign o_pend_mask  = w_mask;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register-file write port between the writeback
//                stage and buffered MDU results, with a starvation-forced
//                drain slot and a pending-write mask for hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_pipe_wena,
    input  logic [4:0]               in_pipe_addr,
    input  logic [31:0]              in_pipe_data,
    input  logic                     in_mdu_valid,
    input  logic [4:0]               in_mdu_addr,
    input  logic [31:0]              in_mdu_data,
    output logic                     out_mdu_ready,
    output logic                     out_rd_wena,
    output logic [4:0]               out_rd_addr,
    output logic [31:0]              out_rd_data,
    output logic                     out_pipe_stall,
    output logic [31:0]              out_pend_mask,
    output logic [$clog2(DEPTH):0]   out_fifo_count
);

    localparam int                  c_AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_AGE_W-1:0]  c_LIMIT = c_AGE_W'(STARVE_LIMIT);

    state_t               r_state;
    logic [c_AGE_W-1:0]   r_age;

    entry_t               w_head;
    entry_t               w_push_entry;
    logic                 w_head_valid;
    logic                 w_head_live;
    logic                 w_full;
    logic                 w_pipe_act;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_squash;

    assign w_pipe_act    = in_pipe_wena && (in_pipe_addr != REG_ZERO);
    assign w_head_live   = w_head_valid && w_head.live;
    assign out_mdu_ready = !w_full && !in_rst;
    // r0 results are accepted but dropped.
    assign w_push        = in_mdu_valid && out_mdu_ready && (in_mdu_addr != REG_ZERO);
    assign w_push_entry  = '{live: 1'b1, addr: in_mdu_addr, data: in_mdu_data};
    assign out_pipe_stall = (r_state == S_FORCE);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk         (in_clk),
        .i_rst         (in_rst),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .i_squash      (w_squash),
        .i_squash_addr (in_pipe_addr),
        .o_head        (w_head),
        .o_head_valid  (w_head_valid),
        .o_full        (w_full),
        .o_count       (out_fifo_count),
        .o_pend_mask   (out_pend_mask)
    );

    // Write-port mux: force slot drains the head, else pipeline wins, else
    // a live head fills the idle slot; a dead head pops in any write-free cycle.
    always_comb begin
        out_rd_wena = 1'b0;
        out_rd_addr = '0;
        out_rd_data = '0;
        w_pop       = 1'b0;
        w_squash    = 1'b0;
        if (!in_rst) begin
            if (r_state == S_FORCE) begin
                if (w_head_live) begin
                    out_rd_wena = 1'b1;
                    out_rd_addr = w_head.addr;
                    out_rd_data = w_head.data;
                    w_pop       = 1'b1;
                end
            end else if (w_pipe_act) begin
                out_rd_wena = 1'b1;
                out_rd_addr = in_pipe_addr;
                out_rd_data = in_pipe_data;
                w_squash    = 1'b1;
            end else if (w_head_live) begin
                out_rd_wena = 1'b1;
                out_rd_addr = w_head.addr;
                out_rd_data = w_head.data;
                w_pop       = 1'b1;
            end
            if (!out_rd_wena && w_head_valid && !w_head.live) begin
                w_pop = 1'b1;
            end
        end
    end

    // Head age counter and NORMAL/FORCE state machine.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= S_NORMAL;
            r_age   <= '0;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if ((r_age == c_LIMIT) && w_head_live) begin
                        r_state <= S_FORCE;
                    end
                end
                default: r_state <= S_NORMAL;
            endcase
            if (w_pop || !w_head_live) begin
                r_age <= '0;
            end else if (r_age != c_LIMIT) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter: queue-based
//                reference model compared every cycle, plus directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wena = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_addr  = '0;
    logic [31:0] mdu_data  = '0;
    logic        mdu_ready;
    logic        rd_wena;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pipe_stall;
    logic [31:0] pend_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_pipe_wena   (pipe_wena),
        .in_pipe_addr   (pipe_addr),
        .in_pipe_data   (pipe_data),
        .in_mdu_valid   (mdu_valid),
        .in_mdu_addr    (mdu_addr),
        .in_mdu_data    (mdu_data),
        .out_mdu_ready  (mdu_ready),
        .out_rd_wena    (rd_wena),
        .out_rd_addr    (rd_addr),
        .out_rd_data    (rd_data),
        .out_pipe_stall (pipe_stall),
        .out_pend_mask  (pend_mask),
        .out_fifo_count (fifo_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an ordered queue of pending MDU writes.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ment_t;

    ment_t       m_q[$];
    int          m_age   = 0;
    bit          m_force = 1'b0;
    logic [31:0] shadow [32];

    // Compare DUT outputs against the model, then advance the model by one edge.
    always @(negedge clk) begin : p_model
        bit          hp, hl, pa, wr, from_head, pop, nf, e_ready;
        logic [4:0]  ea;
        logic [31:0] ed, em;
        if (rst) begin
            m_q.delete();
            m_age   = 0;
            m_force = 1'b0;
        end
        hp = (m_q.size() > 0);
        hl = 1'b0;
        if (hp) hl = m_q[0].live;
        pa = pipe_wena && (pipe_addr != 5'd0);
        wr = 1'b0; from_head = 1'b0; ea = '0; ed = '0;
        if (!rst) begin
            if (m_force) begin
                if (hl) begin wr = 1'b1; from_head = 1'b1; ea = m_q[0].addr; ed = m_q[0].data; end
            end else if (pa) begin
                wr = 1'b1; ea = pipe_addr; ed = pipe_data;
            end else if (hl) begin
                wr = 1'b1; from_head = 1'b1; ea = m_q[0].addr; ed = m_q[0].data;
            end
        end
        em = '0;
        foreach (m_q[i]) if (m_q[i].live) em[m_q[i].addr] = 1'b1;
        e_ready = !rst && (m_q.size() < DEPTH);

        chk("m_ready", 64'(mdu_ready), 64'(e_ready));
        chk("m_count", 64'(fifo_count), 64'(m_q.size()));
        chk("m_mask",  64'(pend_mask), 64'(em));
        chk("m_stall", 64'(pipe_stall), 64'(m_force));
        chk("m_wena",  64'(rd_wena), 64'(wr));
        chk("m_waddr", 64'(rd_addr), 64'(ea));
        chk("m_wdata", 64'(rd_data), 64'(ed));

        if (rd_wena === 1'b1) shadow[rd_addr] = rd_data;

        if (!rst) begin
            pop = from_head || (!wr && hp && !hl);
            nf  = !m_force && (m_age == STARVE_LIMIT) && hl;
            if (pop || !hl) m_age = 0;
            else if (m_age < STARVE_LIMIT) m_age++;
            m_force = nf;
            if (wr && !from_head) begin
                foreach (m_q[i]) if (m_q[i].addr == ea) m_q[i].live = 1'b0;
            end
            if (pop) void'(m_q.pop_front());
            if (mdu_valid && e_ready && (mdu_addr != 5'd0))
                m_q.push_back('{live: 1'b1, addr: mdu_addr, data: mdu_data});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_wena = pw; pipe_addr = pa; pipe_data = pd;
        mdu_valid = mv; mdu_addr  = ma; mdu_data  = md;
    endtask

    initial begin : p_main
        bit found;
        int cyc;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(mdu_ready), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_wena",  64'(rd_wena), 64'd0);
        chk("rst_mask",  64'(pend_mask), 64'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(mdu_ready), 64'd1);

        // Idle pipeline: MDU result drains the next cycle
        step(); drive(0, 0, 0, 1, 5'd5, 32'h1234);
        @(negedge clk);
        step(); drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_wena", 64'(rd_wena), 64'd1);
        chk("idle_addr", 64'(rd_addr), 64'd5);
        chk("idle_data", 64'(rd_data), 64'h1234);
        chk("idle_mask", 64'(pend_mask), 64'h20);
        step();
        @(negedge clk);
        chk("idle_mask_clr", 64'(pend_mask), 64'd0);
        chk("idle_wena_clr", 64'(rd_wena), 64'd0);

        // Fill while the pipeline is busy, then starvation forces r1 out
        for (int k = 1; k <= 4; k++) begin
            step(); drive(1, 5'd10, $urandom, 1, 5'(k), 32'h100 + 32'(k));
            @(negedge clk);
        end
        step(); drive(1, 5'd10, $urandom, 0, 0, 0);
        @(negedge clk);
        chk("fill_count", 64'(fifo_count), 64'd4);
        chk("fill_ready", 64'(mdu_ready), 64'd0);
        found = 1'b0; cyc = -1;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); drive(1, 5'd10, $urandom, 0, 0, 0);
            @(negedge clk);
            if (pipe_stall === 1'b1) begin found = 1'b1; cyc = i; end
        end
        chk("force_seen",  64'(found), 64'd1);
        chk("force_delay", 64'(cyc), 64'd5);
        chk("force_addr",  64'(rd_addr), 64'd1);
        chk("force_data",  64'(rd_data), 64'h101);
        step(); drive(1, 5'd10, 32'hC0DE, 0, 0, 0);
        @(negedge clk);
        chk("after_force_stall", 64'(pipe_stall), 64'd0);
        chk("after_force_addr",  64'(rd_addr), 64'd10);
        for (int i = 0; i < 40; i++) begin
            step(); drive(1, 5'd10, $urandom, 0, 0, 0);
        end
        step(); drive(0, 0, 0, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_count == 0) found = 1'b1;
            else step();
        end
        chk("drained", 64'(found), 64'd1);

        // WAW squash: younger pipeline write kills queued r7
        step(); drive(1, 5'd3, 32'h1, 1, 5'd7, 32'hAAAA);
        @(negedge clk);
        step(); drive(1, 5'd7, 32'hBBBB, 0, 0, 0);
        @(negedge clk);
        chk("waw_mask_set", 64'(pend_mask), 64'h80);
        chk("waw_wdata",    64'(rd_data), 64'hBBBB);
        step(); drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_mask_clr", 64'(pend_mask), 64'd0);
        chk("waw_dead_nowr", 64'(rd_wena), 64'd0);
        chk("waw_dead_cnt", 64'(fifo_count), 64'd1);
        step();
        @(negedge clk);
        chk("waw_popped", 64'(fifo_count), 64'd0);
        chk("waw_r7", 64'(shadow[7]), 64'hBBBB);

        // r0 handling
        step(); drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
        @(negedge clk);
        step(); drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_count", 64'(fifo_count), 64'd0);
        chk("r0_nowr",  64'(rd_wena), 64'd0);
        step(); drive(1, 5'd9, 32'h9, 1, 5'd6, 32'h6666);
        @(negedge clk);
        step(); drive(1, 5'd0, 32'h5555, 0, 0, 0);
        @(negedge clk);
        chk("r0_pipe_addr", 64'(rd_addr), 64'd6);
        chk("r0_pipe_data", 64'(rd_data), 64'h6666);

        // Reset with entries queued
        for (int k = 0; k < 3; k++) begin
            step(); drive(1, 5'd11, $urandom, 1, 5'(12 + k), $urandom);
        end
        step(); rst = 1'b1; drive(1, 5'd11, 32'h77, 0, 0, 0);
        @(negedge clk);
        chk("midrst_count", 64'(fifo_count), 64'd0);
        chk("midrst_mask",  64'(pend_mask), 64'd0);
        chk("midrst_ready", 64'(mdu_ready), 64'd0);
        chk("midrst_wena",  64'(rd_wena), 64'd0);
        step(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_ready_after", 64'(mdu_ready), 64'd1);
        chk("midrst_nowr", 64'(rd_wena), 64'd0);

        // Randomized traffic with a narrow address range to provoke squashes
        for (int i = 0; i < 400; i++) begin
            step();
            rst = (i == 200);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        step(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
        repeat (30) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
